etapa_decodificacion: RTL and testbench

Parametrised, pipelined instruction-decode stage for the MIPS datapath. Decodes one 32-bit instruction per transfer, reads two operands from an internal multi-ported register file with a write-back port and same-cycle write-through bypass, and selects the second operand and destination register. It derives the 4-bit ALU function from the `funct` field and presents everything through one registered ID/EX stage with a valid/ready handshake and flush.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/banco_registros_p.sv | 47 ++++
 rtl/etapa_decodificacion.sv | 102 ++++++++++
 tb/tb_etapa_decodificacion.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: R-type funct codes and the 4-bit ALU control
// codes produced by the decode stage.
package mips_pkg;

   typedef logic [3:0] alu_func_t;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam alu_func_t ALU_ADD = 4'b0010;
   localparam alu_func_t ALU_SUB = 4'b0110;
   localparam alu_func_t ALU_AND = 4'b0000;
   localparam alu_func_t ALU_OR  = 4'b0001;
   localparam alu_func_t ALU_NOR = 4'b1100;
   localparam alu_func_t ALU_SLT = 4'b0111;
   localparam alu_func_t ALU_INV = 4'b1111;

endpackage

// File: rtl/banco_registros_p.sv
// Register file: 2 read ports, 1 write port, same-cycle write-through bypass.
// Register 0 is hardwired to zero and out-of-range addresses read as zero.
module banco_registros_p #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [REG_AW-1:0] rd_addr1,
   input  logic [REG_AW-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2
);

   // Register 0 has no storage at all; entries 1..NREG-1 only.
   logic [NREG-1:1][DATA_W-1:0] regs;
   logic                        wr_ok;

   assign wr_ok = we && (wr_addr != '0) && (32'(wr_addr) < NREG);

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (wr_ok && wr_addr == REG_AW'(i)) regs[i] <= wr_data;
         end
      end
   end

   // Unmatched addresses (0 and >= NREG) fall through to zero.
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (rd_addr1 == REG_AW'(i)) rd_data1 = regs[i];
         if (rd_addr2 == REG_AW'(i)) rd_data2 = regs[i];
      end
      if (wr_ok && wr_addr == rd_addr1) rd_data1 = wr_data;
      if (wr_ok && wr_addr == rd_addr2) rd_data2 = wr_data;
   end

endmodule

// File: rtl/etapa_decodificacion.sv
// MIPS instruction-decode stage: operand fetch, operand/destination muxing,
// ALU-control decode and a single ID/EX register with valid/ready and flush.
module etapa_decodificacion
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruccion,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sel,
   input  logic              sel2,
   input  logic              flush,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] salida1,
   output logic [DATA_W-1:0] salida2,
   output logic [3:0]        salida3,
   output logic [REG_AW-1:0] dest,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [REG_AW-1:0] rs, rt, rd;
   logic [15:0]       imm;
   logic [5:0]        funct;
   logic [DATA_W-1:0] rs_data, rt_data, imm_ext, op2;
   logic [REG_AW-1:0] dst_sel;
   alu_func_t         alu_f;
   logic              xfer_in;
   logic              unused_opcode;

   assign rs    = REG_AW'(instruccion[25:21]);
   assign rt    = REG_AW'(instruccion[20:16]);
   assign rd    = REG_AW'(instruccion[15:11]);
   assign imm   = instruccion[15:0];
   assign funct = instruccion[5:0];
   assign unused_opcode = &{1'b0, instruccion[31:26]};

   banco_registros_p #(
      .DATA_W(DATA_W),
      .NREG  (NREG),
      .REG_AW(REG_AW)
   ) u_banco (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr1(rs),
      .rd_addr2(rt),
      .rd_data1(rs_data),
      .rd_data2(rt_data)
   );

   assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};
   assign op2     = sel2 ? imm_ext : rt_data;
   assign dst_sel = sel ? rd : rt;

   always_comb begin
      alu_f = ALU_INV;
      case (funct)
         FUNCT_ADD: alu_f = ALU_ADD;
         FUNCT_SUB: alu_f = ALU_SUB;
         FUNCT_AND: alu_f = ALU_AND;
         FUNCT_OR:  alu_f = ALU_OR;
         FUNCT_NOR: alu_f = ALU_NOR;
         FUNCT_SLT: alu_f = ALU_SLT;
         default:   alu_f = ALU_INV;
      endcase
   end

   // Ready ignores in_valid and flush so upstream never sees a combinational loop.
   assign in_ready = !out_valid || out_ready;
   assign xfer_in  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         salida1   <= '0;
         salida2   <= '0;
         salida3   <= '0;
         dest      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer_in) begin
         out_valid <= 1'b1;
         salida1   <= rs_data;
         salida2   <= op2;
         salida3   <= alu_f;
         dest      <= dst_sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_etapa_decodificacion.sv
// Scoreboard bench for etapa_decodificacion: a driver keeps an architectural
// model and queues expected results; a negedge monitor compares and pops.
module tb_etapa_decodificacion;

   typedef struct packed {
      logic [31:0] s1;
      logic [31:0] s2;
      logic [3:0]  f;
      logic [4:0]  d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, sel, sel2, flush, we, out_valid, out_ready;
   logic [31:0] instruccion, wr_data, salida1, salida2;
   logic [4:0]  wr_addr, dest;
   logic [3:0]  salida3;

   int ncmp = 0, nfail = 0, npush = 0, npop = 0, ndrop = 0;
   logic        mvalid = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] mregs [32];
   exp_t        q[$];

   always #5 clk = ~clk;

   etapa_decodificacion dut (
      .clk(clk), .rst(rst), .instruccion(instruccion), .in_valid(in_valid),
      .in_ready(in_ready), .sel(sel), .sel2(sel2), .flush(flush), .we(we),
      .wr_addr(wr_addr), .wr_data(wr_data), .salida1(salida1), .salida2(salida2),
      .salida3(salida3), .dest(dest), .out_valid(out_valid), .out_ready(out_ready)
   );

   function automatic logic [3:0] alu_ref(input int f);
      case (f)
         32: return 4'd2;
         34: return 4'd6;
         36: return 4'd0;
         37: return 4'd1;
         39: return 4'd12;
         42: return 4'd7;
         default: return 4'd15;
      endcase
   endfunction

   // Architectural read as seen this cycle, including the pending write.
   function automatic logic [31:0] rd_ref(input int a);
      if (a == 0) return 32'd0;
      if (we && int'(wr_addr) == a) return wr_data;
      return mregs[a];
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_edge();
      logic xin, consumed;
      exp_t e;
      xin      = in_valid && (!mvalid || out_ready);
      consumed = mvalid && out_ready;
      if (rst) begin
         ndrop += q.size();
         q.delete();
         mvalid = 1'b0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else begin
         if (flush) begin
            ndrop += q.size();
            q.delete();
            mvalid = 1'b0;
         end else if (xin) begin
            e.s1 = rd_ref(int'(instruccion[25:21]));
            e.s2 = sel2 ? 32'($signed(instruccion[15:0])) : rd_ref(int'(instruccion[20:16]));
            e.f  = alu_ref(int'(instruccion[5:0]));
            e.d  = sel ? instruccion[15:11] : instruccion[20:16];
            q.push_back(e);
            npush++;
            mvalid = 1'b1;
         end else if (consumed) begin
            mvalid = 1'b0;
         end
         if (we && wr_addr != 5'd0) mregs[wr_addr] = wr_data;
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ins, input logic s, input logic s2,
                       input logic fl, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy, input logic r);
      in_valid = iv; instruccion = ins; sel = s; sel2 = s2; flush = fl;
      we = w; wr_addr = wa; wr_data = wd; out_ready = ordy; rst = r;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 64'(out_valid), 64'(mvalid));
         chk("in_ready", 64'(in_ready), 64'(!mvalid || out_ready));
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
               ncmp++;
               if ({salida1, salida2, salida3, dest} !== q[0]) begin
                  nfail++;
                  $display("FAIL decode: got %h %h %h %h expected %h %h %h %h",
                           salida1, salida2, salida3, dest, q[0].s1, q[0].s2, q[0].f, q[0].d);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  npop++;
               end
            end
         end
      end
   end

   initial begin
      int fset [6] = '{32, 34, 36, 37, 39, 42};
      logic [31:0] held1;
      int pop0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_salida1", 64'(salida1), 64'd0);
      chk("rst_salida2", 64'(salida2), 64'd0);
      chk("rst_salida3", 64'(salida3), 64'd0);
      chk("rst_dest", 64'(dest), 64'd0);
      mon_en = 1'b1;

      // add $3,$5,$0 after writing R5
      step(0, 0, 0, 0, 0, 1, 5, 32'hAA, 1, 0);
      step(1, 32'h00A01820, 1, 0, 0, 0, 0, 0, 1, 0);
      chk("add_salida1", 64'(salida1), 64'hAA);
      chk("add_salida2", 64'(salida2), 64'd0);
      chk("add_salida3", 64'(salida3), 64'b0010);
      chk("add_dest", 64'(dest), 64'd3);

      // bypass on R7, then writes to R0 are ignored
      step(1, rtype(7, 0, 1, 34), 0, 0, 0, 1, 7, 32'h1234, 1, 0);
      chk("bypass_salida1", 64'(salida1), 64'h1234);
      step(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
      step(1, rtype(0, 0, 2, 36), 0, 0, 0, 0, 0, 0, 1, 0);
      chk("r0_salida1", 64'(salida1), 64'd0);
      chk("r0_salida2", 64'(salida2), 64'd0);

      step(1, {6'h08, 5'd5, 5'd4, 16'h8001}, 0, 1, 0, 0, 0, 0, 1, 0);
      chk("sext_salida2", 64'(salida2), 64'hFFFF_8001);
      step(1, rtype(5, 7, 9, 63), 1, 0, 0, 0, 0, 0, 1, 0);
      chk("inv_salida3", 64'(salida3), 64'b1111);

      // stall: three cycles of backpressure, then release
      held1 = salida1;
      for (int i = 0; i < 3; i++) begin
         step(1, rtype(3, 5, 6, 42), 1, 0, 0, 0, 0, 0, 0, 0);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_hold", 64'(salida1), 64'(held1));
      end
      step(1, rtype(3, 5, 6, 42), 1, 0, 0, 0, 0, 0, 1, 0);
      chk("release_salida3", 64'(salida3), 64'b0111);

      pop0 = npop;
      for (int i = 0; i < 10; i++)
         step(1, rtype(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), fset[i % 6]), 1'($urandom), 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("b2b_count", 64'(npop - pop0), 64'd11);

      step(1, rtype(5, 5, 5, 32), 0, 0, 1, 0, 0, 0, 1, 0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         ins = $urandom;
         if ($urandom_range(0, 3) != 0) ins[5:0] = 6'(fset[$urandom_range(0, 5)]);
         step(1'($urandom_range(0, 3) != 0), ins, 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom), $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) == 0));
      end

      // reset in the middle of a stall, then sweep every register
      for (int i = 1; i < 32; i++) step(0, 0, 0, 0, 0, 1, 5'(i), $urandom | 32'h1, 1, 0);
      step(1, rtype(4, 6, 8, 37), 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, rtype(4, 6, 8, 37), 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, rtype(4, 6, 8, 37), 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_stall_out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 32; i++) begin
         step(1, rtype(i, (i + 1) % 32, i, 32), 0, 0, 0, 0, 0, 0, 1, 0);
         chk("rst_clears_reg", 64'(salida1), 64'd0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("scoreboard_balance", 64'(npush), 64'(npop + ndrop + q.size()));
      chk("scoreboard_empty", 64'(q.size()), 64'd0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
